// File: rtl/cla_pkg.sv
// ----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the serial carry-look-ahead adder:
//   NIBBLE_W         width of one look-ahead slice (bits per add cycle)
//   state_e          controller states (IDLE, ADD, DONE)
//   nibble_count_ok  elaboration-time legality check for operand widths
// ----------------------------------------------------------------------------
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // An operand width is legal when it splits into at least one whole nibble.
  function automatic bit nibble_count_ok(input int width);
    return (width >= NIBBLE_W) && ((width % NIBBLE_W) == 0);
  endfunction

endpackage

// File: rtl/cla_serial_adder_if.sv
// ----------------------------------------------------------------------------
// cla_serial_adder_if
// Operand/result handshake bundle for cla_serial_adder.
//   in_valid/in_ready    operand handshake (a, b, cin)
//   out_valid/out_ready  result handshake (sum, cout, ovf)
// Modports:
//   master  producer/consumer side (drives operands, accepts results)
//   slave   adder side
// ----------------------------------------------------------------------------
interface cla_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cla4_slice.sv
// ----------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-look-ahead adder slice.
//   a, b  4-bit addends
//   ci    carry into bit 0
//   s     4-bit sum
//   co    carry out of bit 3
//   c3    carry into bit 3 (used for signed overflow on the top nibble)
// ----------------------------------------------------------------------------
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p/ci, so no carry waits on a
  // lower carry.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];
  assign c3 = c[3];

endmodule

// File: rtl/cla_serial_adder.sv
// ----------------------------------------------------------------------------
// cla_serial_adder
// Multi-cycle WIDTH-bit adder: one nibble per clock through a 4-bit CLA
// slice, with the inter-nibble carry held in a register.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cla_serial_adder_if.slave
//            in_valid/in_ready, a, b, cin       operand handshake
//            out_valid/out_ready, sum, cout, ovf result handshake
// Accept at edge E -> out_valid high after edge E+NIBBLES; result held until
// out_ready; the block returns to IDLE for one cycle before re-accepting.
// ----------------------------------------------------------------------------
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_serial_adder_if.slave  bus
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if (!nibble_count_ok(WIDTH)) begin : g_width_check
    $error("cla_serial_adder: WIDTH (%0d) must be a multiple of 4 and >= 4", WIDTH);
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             cout_q;
  logic             ovf_q;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic                slice_co;
  logic                slice_c3;
  logic                last_nib;

  // Nibble currently being added, selected by the running index.
  assign a_nib    = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign b_nib    = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  cla4_slice u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (slice_co),
    .c3 (slice_c3)
  );

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make the order of statements matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end

        ADD: begin
          sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= s_nib;
          carry_q <= slice_co;
          idx_q   <= idx_q + 1'b1;
          if (last_nib) begin
            // Top nibble: its carry-out is the word carry, and signed
            // overflow is carry into the MSB disagreeing with carry out.
            cout_q  <= slice_co;
            ovf_q   <= slice_co ^ slice_c3;
            idx_q   <= '0;
            state_q <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from state so reset reaches them
  // without waiting for a clock edge.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_cla_serial_adder
// Directed-vector bench for cla_serial_adder (WIDTH = 16). Inputs change
// 1 ns after a rising edge or on the falling edge; outputs are sampled 1 ns
// after a rising edge.
// ----------------------------------------------------------------------------
module tb_cla_serial_adder;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH / 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  cla_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an operation and return 1 ns after the accepting edge.
  // keep_valid leaves in_valid asserted afterwards.
  task automatic accept_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input bit keep_valid);
    int w;
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_in_ready_at_accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid rises (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 50);
  endtask

  // Full single operation with out_ready = 1.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int lat;
    accept_op(tag, a, b, cin, 1'b0);
    check({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
    wait_result(lat);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_sum"},  32'(bus.sum),  32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    check({tag, "_ovf"},  32'(bus.ovf),  32'(exp_ovf));
    @(posedge clk);
    #1;
    check({tag, "_out_valid_one_cycle"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_after"},      32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    int lat;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add and carry / overflow corners
    run_op("basic",    16'h000B, 16'h0007, 1'b0, 16'h0012, 1'b0, 1'b0);
    run_op("ripple0",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("ripple1",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure with operand changes while busy
    bus.out_ready = 1'b0;
    accept_op("bp", 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.a        = 16'hFFFF;
    bus.in_valid = 1'b1;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      check("bp_busy_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid",    32'(bus.out_valid), 32'd1);
      check("bp_hold_sum",      32'(bus.sum),       32'h2345);
      check("bp_hold_in_ready", 32'(bus.in_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);

    // Reset during the second ADD cycle
    accept_op("rst_mid", 16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_sum",       32'(bus.sum),       32'd0);
    check("rst_mid_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("rst_mid_no_pulse", 32'(bus.out_valid), 32'd0);
    end
    run_op("post_rst", 16'h0002, 16'h0004, 1'b1, 16'h0007, 1'b0, 1'b0);

    // Back-to-back with in_valid held high
    accept_op("b2b1", 16'h0001, 16'h0000, 1'b0, 1'b1);
    bus.a   = 16'h0005;
    bus.b   = 16'h0003;
    bus.cin = 1'b1;
    wait_result(lat);
    check("b2b1_latency", 32'(lat),     32'(LAT));
    check("b2b1_sum",     32'(bus.sum), 32'h0001);
    @(posedge clk);
    #1;
    check("b2b_idle_gap_in_ready",  32'(bus.in_ready),  32'd1);
    check("b2b_idle_gap_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("b2b2_accepted", 32'(bus.in_ready), 32'd0);
    wait_result(lat);
    check("b2b2_latency", 32'(lat),      32'(LAT));
    check("b2b2_sum",     32'(bus.sum),  32'h0009);
    check("b2b2_cout",    32'(bus.cout), 32'd0);
    @(posedge clk);
    #1;
    check("b2b2_done", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
